// File: rtl/score_display.sv
// score_display: converts the binary score to BCD with a double-dabble FSM, tracks the
// best score on crash edges and multiplexes four 7-segment digits with blanking and blink.
module score_display #(
   parameter int REFRESH_BITS = 18,
   parameter int BLINK_BITS   = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] score,
   input  logic       colision,
   output logic [3:0] an,
   output logic [7:0] sseg
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t                  state_q, state_d;
   logic [5:0]              last_q, last_d, bin_q, bin_d;
   logic [7:0]              bcd_q, bcd_d, cur_q, cur_d, best_q, best_d, adj;
   logic [2:0]              cnt_q, cnt_d;
   logic [REFRESH_BITS-1:0] refresh_q;
   logic [BLINK_BITS-1:0]   blink_q;
   logic                    col_q, blank;
   logic [1:0]              dig;
   logic [3:0]              nib, an_q, an_d;
   logic [7:0]              sseg_q, sseg_d;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      adj     = {bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
                 bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
      state_d = state_q;
      last_d  = last_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      case (state_q)
         IDLE: if (score != last_q) begin
            bin_d   = score;
            last_d  = score;
            bcd_d   = '0;
            cnt_d   = 3'd6;
            state_d = SHIFT;
         end
         SHIFT: begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q - 3'd1;
            state_d        = cnt_q == 3'd1 ? DONE : SHIFT;
         end
         DONE: begin
            cur_d   = bcd_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Only the rising edge of colision may raise the best score.
   assign best_d = (colision && !col_q && cur_q > best_q) ? cur_q : best_q;

   always_comb begin
      dig    = refresh_q[REFRESH_BITS-1 -: 2];
      nib    = dig == 2'd0 ? cur_q[3:0] : dig == 2'd1 ? cur_q[7:4] :
               dig == 2'd2 ? best_q[3:0] : best_q[7:4];
      blank  = (dig == 2'd1 && cur_q[7:4] == 4'd0) || (dig == 2'd3 && best_q[7:4] == 4'd0) ||
               (colision && blink_q[BLINK_BITS-1] && !dig[1]);
      an_d   = blank ? 4'hF : ~(4'b0001 << dig);
      sseg_d = {dig != 2'd2, seg7(nib)};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= '0;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         cur_q     <= '0;
         best_q    <= '0;
         col_q     <= 1'b0;
         refresh_q <= '0;
         blink_q   <= '0;
         an_q      <= 4'hF;
         sseg_q    <= 8'hFF;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         cur_q     <= cur_d;
         best_q    <= best_d;
         col_q     <= colision;
         refresh_q <= refresh_q + REFRESH_BITS'(1);
         blink_q   <= blink_q + BLINK_BITS'(1);
         an_q      <= an_d;
         sseg_q    <= sseg_d;
      end
   end

   assign an   = an_q;
   assign sseg = sseg_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: compares score_display against an arithmetic model every cycle
// and pins the model with hand-computed display codes.
module tb_score_display;
   localparam int RB = 4;
   localparam int BB = 5;
   logic       clk = 1'b0, reset = 1'b0, colision = 1'b0;
   logic [5:0] score = 6'd0;
   logic [3:0] an;
   logic [7:0] sseg;
   int         checks = 0, failures = 0;

   int         m_cyc = 0, m_t = 0, m_last = 0, m_val = 0;
   logic [7:0] m_cur = 8'h00, m_best = 8'h00;
   logic       m_prev = 1'b0;
   logic [3:0] m_an = 4'hF;
   logic [7:0] m_sseg = 8'hFF;
   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   score_display #(.REFRESH_BITS(RB), .BLINK_BITS(BB)) dut (
      .clk(clk), .reset(reset), .score(score), .colision(colision), .an(an), .sseg(sseg));

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic logic [3:0] exp_an(int c, logic col, logic [7:0] cur, logic [7:0] best);
      int dg = (c / 4) % 4;
      if (dg == 1 && cur[7:4] == 4'd0) return 4'hF;
      if (dg == 3 && best[7:4] == 4'd0) return 4'hF;
      if (dg < 2 && col && ((c / 16) % 2) == 1) return 4'hF;
      return 4'(15 - (1 << dg));
   endfunction

   function automatic logic [7:0] exp_sseg(int c, logic [7:0] cur, logic [7:0] best);
      int dg = (c / 4) % 4;
      int v  = dg == 0 ? int'(cur[3:0]) : dg == 1 ? int'(cur[7:4]) :
               dg == 2 ? int'(best[3:0]) : int'(best[7:4]);
      logic [6:0] s = v > 9 ? 7'h7F : seg_tab[v];
      return {dg != 2, s};
   endfunction

   // A conversion is a 7-edge busy window after the sampling edge, then cur gets the decimal value.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cyc <= 0; m_t <= 0; m_last <= 0; m_val <= 0;
         m_cur <= 8'h00; m_best <= 8'h00; m_prev <= 1'b0;
         m_an <= 4'hF; m_sseg <= 8'hFF;
      end else begin
         m_an   <= exp_an(m_cyc, colision, m_cur, m_best);
         m_sseg <= exp_sseg(m_cyc, m_cur, m_best);
         m_cyc  <= m_cyc + 1;
         if (m_t == 0) begin
            if (int'(score) != m_last) begin
               m_last <= int'(score);
               m_val  <= int'(score);
               m_t    <= 7;
            end
         end else begin
            m_t <= m_t - 1;
            if (m_t == 1) m_cur <= to_bcd(m_val);
         end
         if (colision && !m_prev && m_cur > m_best) m_best <= m_cur;
         m_prev <= colision;
      end
   end

   always @(negedge clk) begin
      checks++;
      if (an !== m_an) begin
         failures++;
         $display("FAIL model_an cyc=%0d got=%b exp=%b", m_cyc, an, m_an);
      end
      checks++;
      if (sseg !== m_sseg) begin
         failures++;
         $display("FAIL model_sseg cyc=%0d got=%b exp=%b", m_cyc, sseg, m_sseg);
      end
   end

   task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ph(input int dg, input int msb);
      for (int i = 0; i < 80; i++) begin
         if (((m_cyc - 1) / 4) % 4 == dg && (msb < 0 || ((m_cyc - 1) / 16) % 2 == msb)) return;
         @(negedge clk);
      end
      failures++;
      $display("FAIL wait_phase timeout dg=%0d msb=%0d", dg, msb);
   endtask

   task automatic pulse_col();
      colision = 1'b1;
      tick(1);
      colision = 1'b0;
      tick(2);
   endtask

   initial begin
      #1 reset = 1'b1;
      @(negedge clk);
      lit("reset_an", 8'(an), 8'h0F);
      lit("reset_sseg", sseg, 8'hFF);
      reset = 1'b0;
      tick(1);
      lit("idle_d0_an", 8'(an), 8'h0E);
      lit("idle_d0_sseg", sseg, 8'hC0);
      wait_ph(1, -1); lit("blank_cur_tens", 8'(an), 8'h0F);
      wait_ph(2, -1); lit("d2_an", 8'(an), 8'h0B); lit("d2_sseg_dp", sseg, 8'h40);
      wait_ph(3, -1); lit("blank_best_tens", 8'(an), 8'h0F);
      score = 6'd37;
      tick(12);
      wait_ph(0, -1); lit("s37_ones", sseg, 8'hF8); lit("s37_d0_an", 8'(an), 8'h0E);
      wait_ph(1, -1); lit("s37_tens", sseg, 8'hB0); lit("s37_d1_an", 8'(an), 8'h0D);
      score = 6'd12;
      tick(12);
      score = 6'd13;
      tick(3);
      score = 6'd45;
      tick(20);
      wait_ph(0, -1); lit("s45_ones", sseg, 8'h92);
      wait_ph(1, -1); lit("s45_tens", sseg, 8'h99);
      pulse_col();
      wait_ph(2, -1); lit("best45_ones", sseg, 8'h12);
      wait_ph(3, -1); lit("best45_tens", sseg, 8'h99); lit("best45_an", 8'(an), 8'h07);
      score = 6'd30;
      tick(12);
      pulse_col();
      wait_ph(3, -1); lit("best_hold45", sseg, 8'h99);
      score = 6'd63;
      tick(12);
      pulse_col();
      wait_ph(3, -1); lit("best63_tens", sseg, 8'h82);
      wait_ph(2, -1); lit("best63_ones", sseg, 8'h30);
      score = 6'd50;
      tick(3);
      #2 reset = 1'b1;
      #1 lit("midshift_rst_an", 8'(an), 8'h0F);
      lit("midshift_rst_sseg", sseg, 8'hFF);
      tick(2);
      reset = 1'b0;
      tick(9);
      wait_ph(1, -1); lit("reconv50_tens", sseg, 8'h92); lit("reconv50_an", 8'(an), 8'h0D);
      wait_ph(0, -1); lit("reconv50_ones", sseg, 8'hC0);
      wait_ph(3, -1); lit("best_cleared_an", 8'(an), 8'h0F);
      score = 6'd20;
      tick(12);
      colision = 1'b1;
      tick(2);
      score = 6'd50;
      tick(12);
      wait_ph(0, 1); lit("blink_d0", 8'(an), 8'h0F);
      wait_ph(1, 1); lit("blink_d1", 8'(an), 8'h0F);
      wait_ph(2, 1); lit("blink_best_d2", 8'(an), 8'h0B);
      wait_ph(0, 0); lit("noblink_d0", 8'(an), 8'h0E);
      wait_ph(1, 0); lit("noblink_d1", 8'(an), 8'h0D);
      wait_ph(3, 1); lit("held_best_tens", sseg, 8'hA4); lit("held_best_an", 8'(an), 8'h07);
      colision = 1'b0;
      tick(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
